// File: rtl/hash_result_serializer.sv
// Serializes one wide hash-result beat into window-filtered (cur, hist) candidates, one per cycle.
// Optional statistics counters are enabled by defining HASH_SERIALIZER_STAT_EN.
module hash_result_serializer #(
    parameter int unsigned ISSUE_WIDTH = 32,
    parameter int unsigned ROW_SIZE    = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    localparam int unsigned SLOT_W     = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [ADDR_WIDTH-1:0]                   cfg_window_size,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [ADDR_WIDTH-1:0]                   in_head_addr,
    input  logic [ISSUE_WIDTH-1:0]                  in_row_valid,
    input  logic [ISSUE_WIDTH*ROW_SIZE-1:0]         in_history_valid_vec,
    input  logic [ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] in_history_addr_vec,
    input  logic                                    in_delim,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ADDR_WIDTH-1:0]                   out_cur_addr,
    output logic [ADDR_WIDTH-1:0]                   out_hist_addr,
    output logic [SLOT_W-1:0]                       out_slot_idx,
    output logic [ADDR_WIDTH-1:0]                   out_distance,
    output logic                                    out_last,
    output logic                                    out_delim,
    output logic                                    out_empty
`ifdef HASH_SERIALIZER_STAT_EN
    ,
    input  logic                                    stat_clear,
    output logic [31:0]                             stat_beats,
    output logic [31:0]                             stat_emitted,
    output logic [31:0]                             stat_dropped
`endif
);

    localparam int unsigned NUM_CAND = ISSUE_WIDTH * ROW_SIZE;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_e;

    state_e                           state_q, state_d;
    logic [NUM_CAND-1:0]              mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]            head_q, head_d;
    logic [NUM_CAND*ADDR_WIDTH-1:0]   hist_q, hist_d;
    logic                             delim_q, delim_d;

    logic [NUM_CAND-1:0]              keep_mask;
    logic [ADDR_WIDTH-1:0]            cand_dist;
    logic [NUM_CAND-1:0]              mask_rest;
    int unsigned                      ffs_idx;
    logic                             ffs_found;
    logic                             accept;
    logic                             out_hs;

    // Keep mask for the beat on the input; wrap-around distances are legal.
    always_comb begin
        keep_mask = '0;
        cand_dist = '0;
        for (int unsigned k = 0; k < NUM_CAND; k++) begin
            cand_dist = in_head_addr + ADDR_WIDTH'(k / ROW_SIZE)
                      - in_history_addr_vec[k*ADDR_WIDTH +: ADDR_WIDTH];
            keep_mask[k] = in_history_valid_vec[k] && in_row_valid[k / ROW_SIZE]
                        && (cand_dist != '0) && (cand_dist <= cfg_window_size);
        end
    end

    always_comb begin
        ffs_idx   = 0;
        ffs_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CAND; k++) begin
            if (mask_q[k] && !ffs_found) begin
                ffs_idx   = k;
                ffs_found = 1'b1;
            end
        end
        mask_rest = mask_q & (mask_q - NUM_CAND'(1));
    end

    always_comb begin
        out_valid     = (state_q == SCAN) || (state_q == FLUSH);
        out_empty     = (state_q == FLUSH);
        out_last      = (state_q == FLUSH) || ((state_q == SCAN) && (mask_rest == '0));
        out_delim     = out_last && delim_q;
        out_cur_addr  = '0;
        out_hist_addr = '0;
        out_slot_idx  = '0;
        out_distance  = '0;
        if (state_q == SCAN) begin
            out_cur_addr  = head_q + ADDR_WIDTH'(ffs_idx / ROW_SIZE);
            out_hist_addr = hist_q[ffs_idx*ADDR_WIDTH +: ADDR_WIDTH];
            out_slot_idx  = SLOT_W'(ffs_idx % ROW_SIZE);
            out_distance  = out_cur_addr - out_hist_addr;
        end
        out_hs   = out_valid && out_ready;
        in_ready = !rst && ((state_q == IDLE) || (out_hs && out_last));
        accept   = in_valid && in_ready;
    end

    // A new beat accepted on the final handshake overrides the return to IDLE.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        head_d  = head_q;
        hist_d  = hist_q;
        delim_d = delim_q;
        if (out_hs) begin
            mask_d = mask_rest;
            if (out_last) state_d = IDLE;
        end
        if (accept) begin
            mask_d  = keep_mask;
            head_d  = in_head_addr;
            hist_d  = in_history_addr_vec;
            delim_d = in_delim;
            if (keep_mask != '0) state_d = SCAN;
            else if (in_delim)   state_d = FLUSH;
            else                 state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            head_q  <= '0;
            hist_q  <= '0;
            delim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            head_q  <= head_d;
            hist_q  <= hist_d;
            delim_q <= delim_d;
        end
    end

`ifdef HASH_SERIALIZER_STAT_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] emitted_q, emitted_d;
    logic [31:0] dropped_q, dropped_d;
    logic [32:0] dropped_sum;
    int unsigned drop_n;

    always_comb begin
        drop_n = 0;
        for (int unsigned k = 0; k < NUM_CAND; k++) begin
            if (in_history_valid_vec[k] && !keep_mask[k]) drop_n++;
        end
        dropped_sum = {1'b0, dropped_q} + 33'(drop_n);

        beats_d   = beats_q;
        emitted_d = emitted_q;
        dropped_d = dropped_q;
        if (accept && (beats_q != '1)) beats_d = beats_q + 32'd1;
        if (out_hs && !out_empty && (emitted_q != '1)) emitted_d = emitted_q + 32'd1;
        if (accept) dropped_d = dropped_sum[32] ? '1 : dropped_sum[31:0];
        if (stat_clear) begin
            beats_d   = '0;
            emitted_d = '0;
            dropped_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q   <= '0;
            emitted_q <= '0;
            dropped_q <= '0;
        end else begin
            beats_q   <= beats_d;
            emitted_q <= emitted_d;
            dropped_q <= dropped_d;
        end
    end

    assign stat_beats   = beats_q;
    assign stat_emitted = emitted_q;
    assign stat_dropped = dropped_q;
`endif

endmodule
